// File: rtl/ascii_dec_parse_if.sv
// +--------------------------------------------------------------------+
// | ascii_dec_parse_if                                                 |
// | Character-in / number-out handshake bundle for ascii_dec_parse.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface ascii_dec_parse_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_overflow;

  // master: character producer and number consumer
  modport master (
    output in_valid,
    output in_char,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_value,
    input  out_overflow
  );

  // slave: the parser itself
  modport slave (
    input  in_valid,
    input  in_char,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_value,
    output out_overflow
  );
endinterface

`default_nettype wire

// File: rtl/ascii_dec_parse.sv
// +--------------------------------------------------------------------+
// | ascii_dec_parse                                                    |
// | Accumulates a run of ASCII decimal digits into a saturating        |
// | unsigned integer, emitted on a valid/ready port at the terminator. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ascii_dec_parse #(
  parameter int WIDTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ascii_dec_parse_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_value;
  logic               r_overflow;

  logic               w_take;
  logic               w_is_digit;
  logic [3:0]         w_digit;
  logic [WIDTH+3:0]   w_acc_ext;
  logic [WIDTH+3:0]   w_mac;
  logic               w_mac_ovf;

  assign w_take     = bus.in_valid && (r_state != S_EMIT);
  assign w_is_digit = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
  assign w_digit    = bus.in_char[3:0];

  // acc*10 + d via shifts; WIDTH+4 bits always holds the unsaturated result
  assign w_acc_ext  = {4'b0000, r_acc};
  assign w_mac      = (w_acc_ext << 3) + (w_acc_ext << 1) + {{WIDTH{1'b0}}, w_digit};
  assign w_mac_ovf  = |w_mac[WIDTH+3:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_value    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take && w_is_digit) begin
            r_acc   <= {{(WIDTH-4){1'b0}}, w_digit};
            r_ovf   <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_take) begin
            if (w_is_digit) begin
              if (r_ovf || w_mac_ovf) begin
                r_acc <= '1;
                r_ovf <= 1'b1;
              end else begin
                r_acc <= w_mac[WIDTH-1:0];
              end
            end else begin
              r_value    <= r_acc;
              r_overflow <= r_ovf;
              r_state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (r_state != S_EMIT);
  assign bus.out_valid    = (r_state == S_EMIT);
  assign bus.out_value    = r_value;
  assign bus.out_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ascii_dec_parse.sv
// +--------------------------------------------------------------------+
// | tb_ascii_dec_parse                                                 |
// | Directed table-driven bench for ascii_dec_parse (WIDTH=16).        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ascii_dec_parse;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;

  int unsigned n_vec;
  int unsigned n_bad;

  ascii_dec_parse_if #(.WIDTH(WIDTH)) b ();

  ascii_dec_parse #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       s;
    int unsigned val;
    bit          ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of inputs; returns at the next falling edge.
  task automatic drive(input bit v, input logic [7:0] c, input bit ordy);
    b.in_valid  = v;
    b.in_char   = c;
    b.out_ready = ordy;
    @(negedge clk);
  endtask

  // Stream a string (last char is the terminator), check the result and handshake it.
  task automatic send(input string s, input int unsigned v, input bit o);
    for (int i = 0; i < s.len(); i++) begin
      chk("in_ready_accept", {31'd0, b.in_ready}, 32'd1);
      drive(1'b1, s[i], 1'b1);
      if (i < s.len() - 1) chk("no_early_out", {31'd0, b.out_valid}, 32'd0);
    end
    chk("out_valid", {31'd0, b.out_valid}, 32'd1);
    chk("out_value", {16'd0, b.out_value}, v);
    chk("out_overflow", {31'd0, b.out_overflow}, {31'd0, o});
    chk("in_ready_emit", {31'd0, b.in_ready}, 32'd0);
    // keep in_valid high during the handshake; the char must not be consumed
    drive(1'b1, "9", 1'b1);
    chk("post_hs_valid", {31'd0, b.out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, b.in_ready}, 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{s: "123,",       val: 123,   ovf: 1'b0};
    tbl[1]  = '{s: "65535\n",    val: 65535, ovf: 1'b0};
    tbl[2]  = '{s: "65536\n",    val: 65535, ovf: 1'b1};
    tbl[3]  = '{s: "9999999 ",   val: 65535, ovf: 1'b1};
    tbl[4]  = '{s: "4 ",         val: 4,     ovf: 1'b0};
    tbl[5]  = '{s: "  /:007x",   val: 7,     ovf: 1'b0};
    tbl[6]  = '{s: "0;",         val: 0,     ovf: 1'b0};
    tbl[7]  = '{s: "65540,",     val: 65535, ovf: 1'b1};
    tbl[8]  = '{s: "100000 ",    val: 65535, ovf: 1'b1};
    tbl[9]  = '{s: "+9-",        val: 9,     ovf: 1'b0};
    tbl[10] = '{s: "65534:",     val: 65534, ovf: 1'b0};

    b.in_valid  = 1'b0;
    b.in_char   = 8'h00;
    b.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", {31'd0, b.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, b.out_valid}, 32'd0);
    chk("rst_out_value", {16'd0, b.out_value}, 32'd0);
    chk("rst_out_ovf", {31'd0, b.out_overflow}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].s, tbl[i].val, tbl[i].ovf);
    end
    drive(1'b0, 8'h00, 1'b1);

    // Backpressure: result held, in_ready low, pending char not consumed
    drive(1'b1, "4", 1'b0);
    drive(1'b1, "2", 1'b0);
    drive(1'b1, ";", 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, b.out_valid}, 32'd1);
      chk("bp_value", {16'd0, b.out_value}, 32'd42);
      chk("bp_in_ready", {31'd0, b.in_ready}, 32'd0);
      drive(1'b1, "5", 1'b0);
    end
    chk("bp_hold_valid", {31'd0, b.out_valid}, 32'd1);
    chk("bp_hold_value", {16'd0, b.out_value}, 32'd42);
    drive(1'b1, "5", 1'b1);
    chk("bp_release_valid", {31'd0, b.out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, b.in_ready}, 32'd1);
    drive(1'b1, "5", 1'b1);
    drive(1'b1, ";", 1'b1);
    chk("bp_next_valid", {31'd0, b.out_valid}, 32'd1);
    chk("bp_next_value", {16'd0, b.out_value}, 32'd5);
    drive(1'b0, 8'h00, 1'b1);

    // Reset mid-number discards the partial value
    drive(1'b1, "1", 1'b1);
    drive(1'b1, "2", 1'b1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    chk("rst_mid_ready", {31'd0, b.in_ready}, 32'd1);
    chk("rst_mid_valid", {31'd0, b.out_valid}, 32'd0);
    send("3,", 3, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // Reset in EMIT wins over a simultaneous handshake and drops the result
    drive(1'b1, "8", 1'b0);
    drive(1'b1, ";", 1'b0);
    chk("emit_pre_rst", {31'd0, b.out_valid}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    chk("emit_rst_valid", {31'd0, b.out_valid}, 32'd0);
    chk("emit_rst_value", {16'd0, b.out_value}, 32'd0);
    chk("emit_rst_ready", {31'd0, b.in_ready}, 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    chk("emit_rst_stays", {31'd0, b.out_valid}, 32'd0);

    // Gapped input: idle cycles (with digit garbage on in_char) change nothing
    drive(1'b1, "8", 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, "7", 1'b1);
      chk("gap_no_out", {31'd0, b.out_valid}, 32'd0);
    end
    send("1 ", 81, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
